// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers tagged ALU commands in a FIFO, drives them into a
// combinational ALU one at a time and returns the captured results in order.
// Optional built-in result checker: define ALU_SCOREBOARD_EN.
module alu_cmd_sequencer #(
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [31:0]                cmd_a,
    input  logic [31:0]                cmd_b,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic [2:0]                 alu_op,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    input  logic [31:0]                alu_y,
    input  logic                       alu_z,
    input  logic                       alu_n,
    input  logic                       alu_c,
    input  logic                       alu_v,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_y,
    output logic [3:0]                 rsp_flags,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_err,
    output logic                       rsp_mismatch,
    output logic [15:0]                mismatch_cnt,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef struct packed {
        logic [2:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, head_legal;
    state_t        state, state_d;
    logic [SW-1:0] settle_cnt;
    logic          ld_alu, ld_err, cap, rsp_done;

    // Ready depends on occupancy only, so a full FIFO never accepts even when
    // the FSM pops in the same cycle; held low throughout reset.
    assign cmd_ready  = rst_n && (fifo_count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];
    assign head_legal = (head.op <= 3'd5);
    assign busy       = (state != IDLE) || (fifo_count != '0);

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d  = state;
        pop      = 1'b0;
        ld_alu   = 1'b0;
        ld_err   = 1'b0;
        cap      = 1'b0;
        rsp_done = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        ld_alu  = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        ld_err  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETTLE: begin
                // counter reaches zero on this edge
                if (settle_cnt == SW'(1)) begin
                    cap     = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // rsp_valid is always high here, so ready alone is the handshake
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU drive, settle counter and response registers. The ALU drive is never
    // cleared between commands; it only changes when a legal command is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            settle_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_y      <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (ld_alu) begin
                alu_op     <= head.op;
                alu_a      <= head.a;
                alu_b      <= head.b;
                settle_cnt <= SW'(SETTLE_CYC);
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            // tag moves while rsp_valid is low, so the response stays stable
            if (pop) rsp_tag <= head.tag;
            if (ld_err) begin
                rsp_y     <= '0;
                rsp_flags <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
            end
            if (cap) begin
                rsp_y     <= alu_y;
                rsp_flags <= {alu_z, alu_n, alu_c, alu_v};
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SCOREBOARD_EN
    logic [31:0] exp_y;
    logic        exp_bad;

    // Reference result from the latched ALU drive; c and v are not modelled.
    always_comb begin
        exp_y = '0;
        case (alu_op)
            3'd0:    exp_y = alu_a + alu_b;
            3'd1:    exp_y = alu_a - alu_b;
            3'd2:    exp_y = alu_a & alu_b;
            3'd3:    exp_y = alu_a | alu_b;
            3'd4:    exp_y = alu_a ^ alu_b;
            3'd5:    exp_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: exp_y = '0;
        endcase
        exp_bad = (alu_y != exp_y) || (alu_z != (exp_y == '0)) || (alu_n != exp_y[31]);
    end

    // Mismatch flag per response and saturating count; illegal ops never compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_mismatch <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (ld_err) rsp_mismatch <= 1'b0;
            if (cap) begin
                rsp_mismatch <= exp_bad;
                if (exp_bad && (mismatch_cnt != 16'hFFFF)) mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end
`else
    assign rsp_mismatch = 1'b0;
    assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed cases plus randomized
// traffic against an in-order expected-response queue.
module tb_alu_cmd_sequencer;
    localparam int DEPTH      = 4;
    localparam int TAG_W      = 4;
    localparam int SETTLE_CYC = 1;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [31:0]      cmd_a = '0, cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [2:0]       alu_op;
    logic [31:0]      alu_a, alu_b, alu_y;
    logic             alu_z, alu_n, alu_c, alu_v;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic [31:0]      rsp_y;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err, rsp_mismatch, busy;
    logic [15:0]      mismatch_cnt;
    logic [CW-1:0]    fifo_count;

    typedef struct {
        logic [31:0]      y;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0, miscompares = 0;
    bit   rnd_done;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .rsp_mismatch(rsp_mismatch), .mismatch_cnt(mismatch_cnt),
        .fifo_count(fifo_count), .busy(busy)
    );

    // Behaviour of the attached ALU: returns {z,n,c,v,y}.
    function automatic logic [35:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] y;
        logic        c, v;
        w = '0; y = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; y = w[31:0]; c = w[32];
                        v = (a[31] == b[31]) && (y[31] != a[31]); end
            3'd1: begin y = a - b; c = (a < b); v = (a[31] != b[31]) && (y[31] != a[31]); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: y = '0;
        endcase
        return {(y == 32'd0), y[31], c, v, y};
    endfunction

    always_comb {alu_z, alu_n, alu_c, alu_v, alu_y} = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every visible response must match the oldest outstanding command,
    // which also covers stability while the consumer stalls.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                mon_e = q[0];
                chk("rsp_y", rsp_y, mon_e.y);
                chk("rsp_flags", rsp_flags, mon_e.flags);
                chk("rsp_tag", rsp_tag, mon_e.tag);
                chk("rsp_err", rsp_err, mon_e.err);
                chk("rsp_mismatch", rsp_mismatch, 0);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    // Offer one command (called just after a rising edge); record expectation on accept.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int          n;
        exp_t        e;
        logic [35:0] r;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n <= 300) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (n > 300) begin
            chk("send_timeout", 0, 1);
        end else begin
            r       = alu_f(op, a, b);
            e.err   = (op > 3'd5);
            e.y     = e.err ? 32'd0 : r[31:0];
            e.flags = e.err ? 4'd0 : r[35:32];
            e.tag   = tag;
            q.push_back(e);
        end
    endtask

    // Send, then count edges until rsp_valid is seen; returns at that falling edge.
    task automatic issue_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag, output int lat);
        send(op, a, b, tag);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_valid || q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_opnd();
        logic [31:0] corner [4];
        corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        int lat, seen;
        // reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mismatch_cnt", mismatch_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // ADD 2+3
        issue_wait(3'd0, 32'd2, 32'd3, 4'd1, lat);
        chk("add_latency", lat, 1 + SETTLE_CYC);
        chk("add_y", rsp_y, 5);
        chk("add_flags", rsp_flags, 4'b0000);
        chk("add_tag", rsp_tag, 1);
        chk("add_err", rsp_err, 0);
        wait_idle();

        // SUB 7-7 -> zero flag
        issue_wait(3'd1, 32'd7, 32'd7, 4'd2, lat);
        chk("sub_y", rsp_y, 0);
        chk("sub_z", rsp_flags[3], 1);
        chk("sub_mismatch", rsp_mismatch, 0);
        wait_idle();

        // SLT -1 < 1 signed
        issue_wait(3'd5, 32'hFFFF_FFFF, 32'd1, 4'd4, lat);
        chk("slt_y", rsp_y, 1);
        chk("slt_zn", rsp_flags[3:2], 2'b00);
        wait_idle();

        // illegal op keeps ALU drive of previous command
        issue_wait(3'd6, 32'hDEAD_BEEF, 32'h1, 4'd3, lat);
        chk("ill_latency", lat, 1);
        chk("ill_err", rsp_err, 1);
        chk("ill_y", rsp_y, 0);
        chk("ill_tag", rsp_tag, 3);
        chk("ill_alu_op_held", alu_op, 5);
        chk("ill_alu_a_held", alu_a, 32'hFFFF_FFFF);
        wait_idle();

        // backpressure: DEPTH+1 outstanding, next one must wait
        rsp_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) send(3'd0, 32'h100 * i, 32'd1, TAG_W'(i));
        cmd_op = 3'd0; cmd_a = 32'h100 * (DEPTH + 1); cmd_b = 32'd1;
        cmd_tag = TAG_W'(DEPTH + 1); cmd_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("full_cmd_ready", cmd_ready, 0);
        end
        chk("full_fifo_count", fifo_count, DEPTH);
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_rsp_tag", rsp_tag, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(3'd0, 32'h100 * (DEPTH + 1), 32'd1, TAG_W'(DEPTH + 1));
        wait_idle();

        // randomized traffic with random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    send(3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), TAG_W'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();

        // reset in the middle of SETTLE with two commands queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd0, 32'h1234_0000 + i, 32'd5, TAG_W'(8 + i));
        seen = 0;
        @(negedge clk);
        while (!rsp_valid && seen < 50) begin seen++; @(negedge clk); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_fifo_count", fifo_count, 2);
        chk("mid_alu_a", alu_a, 32'h1234_0001);
        chk("mid_rsp_valid", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_fifo_count", fifo_count, 0);
        chk("mrst_alu_a", alu_a, 0);
        chk("mrst_alu_op", alu_op, 0);
        chk("mrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mrst_no_rsp", seen, 0);
        chk("mrst_cmd_ready", cmd_ready, 1);

        chk("final_mismatch_cnt", mismatch_cnt, 0);
        chk("final_q_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
